// File: rtl/sr_pkg.sv
// Shared definitions for the SR register bank: conflict-rule encodings and
// the single-channel next-state rule used by every cell.
package sr_pkg;

    // Rule applied when set and reset are both requested on an enabled channel.
    localparam int MODE_HOLD   = 0;
    localparam int MODE_SET    = 1;
    localparam int MODE_RST    = 2;
    localparam int MODE_TOGGLE = 3;

    // Next value of one enabled channel. Unknown mode values fall back to hold.
    function automatic logic sr_next(input int mode, input logic q, input logic s, input logic r);
        logic n;
        n = q;
        case ({s, r})
            2'b10: n = 1'b1;
            2'b01: n = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_SET:    n = 1'b1;
                    MODE_RST:    n = 1'b0;
                    MODE_TOGGLE: n = ~q;
                    default:     n = q;
                endcase
            end
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sr_reg_bank_if.sv
// Bus bundle for sr_reg_bank. Inputs are sampled on every rising clk; outputs
// are all registered. There is no handshake: every edge is a transaction.
interface sr_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             clr;
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             conflict;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output clr, en, s, r,
        input  q, rise, fall, conflict, conflict_cnt
    );

    modport slave (
        input  clr, en, s, r,
        output q, rise, fall, conflict, conflict_cnt
    );
endinterface

// File: rtl/sr_cell.sv
// One SR channel: next-state selection, state register and 0->1 / 1->0 edge
// pulses that appear on the same edge as the state change.
module sr_cell
    import sr_pkg::*;
#(
    parameter int   MODE    = MODE_HOLD,
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_rise,
    output logic o_fall,
    output logic o_conflict
);
    logic r_q;
    logic r_rise;
    logic r_fall;
    logic w_q_next;

    // Next state: a disabled channel keeps its value, so it can never pulse.
    always_comb begin
        w_q_next = r_q;
        if (i_en) begin
            w_q_next = sr_next(MODE, r_q, i_s, i_r);
        end
    end

    // State and edge pulses; clear forces the reset value without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= RST_BIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (i_clr) begin
            r_q    <= RST_BIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_rise <= w_q_next & ~r_q;
            r_fall <= ~w_q_next & r_q;
        end
    end

    // Conflict is seen regardless of the mode that resolves it.
    assign o_conflict = i_en & i_s & i_r;
    assign o_q        = r_q;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent SR channels with a registered any-channel
// conflict flag and a saturating count of edges that carried a conflict.
module sr_reg_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               MODE    = MODE_HOLD,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic           clk,
    input logic           rst,
    sr_reg_bank_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_conflict;
    logic             w_conflict_any;
    logic             r_conflict;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE    (MODE),
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .i_clr      (bus.clr),
            .i_en       (bus.en[i]),
            .i_s        (bus.s[i]),
            .i_r        (bus.r[i]),
            .o_q        (w_q[i]),
            .o_rise     (w_rise[i]),
            .o_fall     (w_fall[i]),
            .o_conflict (w_conflict[i])
        );
    end

    // Several conflicting channels on one edge still count as one event.
    assign w_conflict_any = |w_conflict;

    // Conflict flag and saturating counter; holds at all-ones, never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else if (bus.clr) begin
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_conflict <= w_conflict_any;
            if (w_conflict_any && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.q            = w_q;
    assign bus.rise         = w_rise;
    assign bus.fall         = w_fall;
    assign bus.conflict     = r_conflict;
    assign bus.conflict_cnt = r_cnt;

endmodule
